// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: channel opcodes and the master bridge state encoding.
package tlul_pkg;

  localparam logic [2:0] OP_Get            = 3'd4;
  localparam logic [2:0] OP_PutFullData    = 3'd0;
  localparam logic [2:0] OP_PutPartialData = 3'd1;
  localparam logic [2:0] OP_AccessAck      = 3'd0;
  localparam logic [2:0] OP_AccessAckData  = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AREQ  = 2'd1,
    DWAIT = 2'd2,
    RSP   = 2'd3
  } tlul_mst_state_t;

endpackage

// File: rtl/tlul_master_bridge_if.sv
// Command/response side plus TL-UL channels A and D of the master bridge, bundled as one interface.
interface tlul_master_bridge_if #(
  parameter int W = 8,
  parameter int A = 32,
  parameter int Z = 4,
  parameter int O = 5,
  parameter int I = 5
);
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [A-1:0]   req_addr;
  logic [Z-1:0]   req_size;
  logic [8*W-1:0] req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [8*W-1:0] rsp_rdata;
  logic           rsp_error;

  logic [2:0]     a_opcode;
  logic [2:0]     a_param;
  logic [Z-1:0]   a_size;
  logic [O-1:0]   a_source;
  logic [A-1:0]   a_address;
  logic [W-1:0]   a_mask;
  logic [8*W-1:0] a_data;
  logic           a_valid;
  logic           a_ready;

  logic [2:0]     d_opcode;
  logic [1:0]     d_param;
  logic [Z-1:0]   d_size;
  logic [O-1:0]   d_source;
  logic [I-1:0]   d_sink;
  logic [8*W-1:0] d_data;
  logic           d_error;
  logic           d_valid;
  logic           d_ready;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready, a_ready,
           d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error, d_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid, d_ready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready, a_ready,
           d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error, d_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid, d_ready
  );

endinterface

// File: rtl/tlul_lane_mask.sv
// Byte-lane helper: byte mask for (size, offset), write data shifted up to the lane,
// and read data shifted down from the lane with bytes beyond 2^size cleared.
module tlul_lane_mask #(
  parameter  int W  = 8,
  parameter  int Z  = 4,
  localparam int LW = $clog2(W)
) (
  input  logic [Z-1:0]   size_i,
  input  logic [LW-1:0]  off_i,
  input  logic [8*W-1:0] up_i,
  input  logic [8*W-1:0] down_i,
  output logic [W-1:0]   mask_o,
  output logic [8*W-1:0] up_o,
  output logic [8*W-1:0] down_o
);

  logic [8*W-1:0] down_shift_s;

  assign up_o         = up_i << {off_i, 3'b000};
  assign down_shift_s = down_i >> {off_i, 3'b000};

  always_comb begin
    int span;
    mask_o = '0;
    down_o = '0;
    span   = 32'sd1 << size_i;
    for (int i = 0; i < W; i++) begin
      mask_o[i]        = (i >= int'(off_i)) && (i < int'(off_i) + span);
      down_o[8*i +: 8] = (i < span) ? down_shift_s[8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/tlul_master_bridge.sv
// Single-outstanding TL-UL master: one command becomes one A beat, the D beat becomes the response.
// Optional D-wait timeout is built when TLUL_MASTER_TIMEOUT_EN is defined.
module tlul_master_bridge
  import tlul_pkg::*;
#(
  parameter int W         = 8,
  parameter int A         = 32,
  parameter int Z         = 4,
  parameter int O         = 5,
  parameter int I         = 5,
  parameter int SOURCE_ID = 0,
  parameter int TIMEOUT   = 255
) (
  input logic                CLK,
  input logic                RESET,
  tlul_master_bridge_if.master bus
);

  localparam int LW = $clog2(W);
  localparam int DW = 8 * W;

  tlul_mst_state_t state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_error_q, rsp_error_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          a_valid_q, a_valid_d;
  logic [2:0]    a_opcode_q, a_opcode_d;
  logic [Z-1:0]  a_size_q, a_size_d;
  logic [O-1:0]  a_source_q, a_source_d;
  logic [A-1:0]  a_address_q, a_address_d;
  logic [W-1:0]  a_mask_q, a_mask_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          d_ready_q, d_ready_d;

  logic [Z-1:0]  lm_size_s;
  logic [LW-1:0] lm_off_s;
  logic [W-1:0]  lm_mask_s;
  logic [DW-1:0] lm_up_s, lm_down_s;
  logic          a_fire_s, d_fire_s, discard_s, illegal_s, is_get_s, d_bad_s;
  logic [DW-1:0] d_rdata_s;
  logic          unused_d;

  assign unused_d = ^{bus.d_param, bus.d_sink};

  // The lane helper serves the incoming command in IDLE and the stored A beat afterwards.
  assign lm_size_s = (state_q == IDLE) ? bus.req_size : a_size_q;
  assign lm_off_s  = (state_q == IDLE) ? bus.req_addr[LW-1:0] : a_address_q[LW-1:0];

  tlul_lane_mask #(.W(W), .Z(Z)) u_lane (
    .size_i (lm_size_s),
    .off_i  (lm_off_s),
    .up_i   (bus.req_wdata),
    .down_i (bus.d_data),
    .mask_o (lm_mask_s),
    .up_o   (lm_up_s),
    .down_o (lm_down_s)
  );

  assign illegal_s = (bus.req_size > Z'(LW)) ||
                     (|(bus.req_addr[LW-1:0] & ~({LW{1'b1}} << bus.req_size)));
  assign is_get_s  = (a_opcode_q == OP_Get);
  assign d_bad_s   = bus.d_error ||
                     (bus.d_opcode != (is_get_s ? OP_AccessAckData : OP_AccessAck)) ||
                     (bus.d_source != O'(SOURCE_ID)) ||
                     (bus.d_size != a_size_q);
  assign d_rdata_s = is_get_s ? lm_down_s : '0;
  assign a_fire_s  = a_valid_q && bus.a_ready;
  assign d_fire_s  = d_ready_q && bus.d_valid && !discard_s;

`ifdef TLUL_MASTER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stale_q, stale_d;

  // After a timeout, one late D beat with a foreign source is swallowed instead of completing.
  assign discard_s = stale_q && d_ready_q && bus.d_valid && (bus.d_source != O'(SOURCE_ID));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign discard_s = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_size_d    = a_size_q;
    a_source_d  = a_source_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
`ifdef TLUL_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    stale_d = discard_s ? 1'b0 : stale_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          if (illegal_s) begin
            state_d     = RSP;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = AREQ;
            a_valid_d   = 1'b1;
            a_opcode_d  = !bus.req_write ? OP_Get :
                          (bus.req_size == Z'(LW)) ? OP_PutFullData : OP_PutPartialData;
            a_size_d    = bus.req_size;
            a_source_d  = O'(SOURCE_ID);
            a_address_d = bus.req_addr;
            a_mask_d    = lm_mask_s;
            a_data_d    = lm_up_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      AREQ: begin
        if (d_fire_s) begin
          // A D beat before our A beat was accepted cannot belong to this request.
          state_d     = RSP;
          a_valid_d   = 1'b0;
          rsp_error_d = a_fire_s ? d_bad_s : 1'b1;
          rsp_rdata_d = a_fire_s ? d_rdata_s : '0;
        end else if (a_fire_s) begin
          state_d   = DWAIT;
          a_valid_d = 1'b0;
`ifdef TLUL_MASTER_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else begin
          state_d = AREQ;
        end
      end
      DWAIT: begin
        if (d_fire_s) begin
          state_d     = RSP;
          rsp_error_d = d_bad_s;
          rsp_rdata_d = d_rdata_s;
        end else begin
          state_d = DWAIT;
`ifdef TLUL_MASTER_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT)) begin
            state_d     = RSP;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
            stale_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_error_d = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = RSP;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    d_ready_d   = (state_d == AREQ) || (state_d == DWAIT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= 3'd0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_size_q    <= a_size_d;
      a_source_q  <= a_source_d;
      a_address_q <= a_address_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.a_opcode  = a_opcode_q;
  assign bus.a_param   = 3'b000;
  assign bus.a_size    = a_size_q;
  assign bus.a_source  = a_source_q;
  assign bus.a_address = a_address_q;
  assign bus.a_mask    = a_mask_q;
  assign bus.a_data    = a_data_q;
  assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_tlul_master_bridge.sv
// Directed bench for tlul_master_bridge with a small in-bench TL-UL memory slave (byte i = i).
module tb_tlul_master_bridge;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  tlul_master_bridge_if #(.W(8), .A(32), .Z(4), .O(5), .I(5)) bus ();

  tlul_master_bridge #(
    .W(8), .A(32), .Z(4), .O(5), .I(5), .SOURCE_ID(0), .TIMEOUT(4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:255];
  logic [2:0]  cap_op;
  logic [7:0]  cap_mask;
  logic [63:0] cap_data;
  logic [31:0] cap_addr;
  logic [3:0]  cap_size;
  logic        inj_op_en;
  logic [2:0]  inj_op;
  logic [4:0]  inj_src;
  logic        inj_err;
  logic        same_cycle;
  logic [63:0] r_data;
  logic        r_err;
  logic [63:0] held_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic w, input logic [31:0] addr, input logic [3:0] size,
                          input logic [63:0] wdata);
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge CLK);
    check_val("req_ready_wait", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    @(negedge CLK);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 20 && !bus.a_valid; i++) @(negedge CLK);
    check_val("a_valid_wait", 64'(bus.a_valid), 64'd1);
    cap_op   = bus.a_opcode;
    cap_mask = bus.a_mask;
    cap_data = bus.a_data;
    cap_addr = bus.a_address;
    cap_size = bus.a_size;
  endtask

  // Memory slave: apply a Put using the captured mask, return the aligned word for a Get.
  task automatic slave_d();
    logic [7:0]  idx;
    logic [63:0] rd;
    rd = '0;
    for (int b = 0; b < 8; b++) begin
      idx = {cap_addr[7:3], 3'(b)};
      if (cap_op != 3'd4 && cap_mask[b]) mem[idx] = cap_data[8*b +: 8];
      rd[8*b +: 8] = mem[idx];
    end
    bus.d_opcode = inj_op_en ? inj_op : ((cap_op == 3'd4) ? 3'd1 : 3'd0);
    bus.d_size   = cap_size;
    bus.d_source = inj_src;
    bus.d_error  = inj_err;
    bus.d_data   = (cap_op == 3'd4) ? rd : 64'h0;
    bus.d_valid  = 1'b1;
  endtask

  task automatic txn(input logic w, input logic [31:0] addr, input logic [3:0] size,
                     input logic [63:0] wdata, input int hold);
    send_req(w, addr, size, wdata);
    wait_a();
    bus.a_ready = 1'b1;
    if (same_cycle) slave_d();
    @(negedge CLK);
    bus.a_ready = 1'b0;
    if (!same_cycle) begin
      slave_d();
      @(negedge CLK);
    end
    bus.d_valid = 1'b0;
    check_val("rsp_latency", 64'(bus.rsp_valid), 64'd1);
    r_data = bus.rsp_rdata;
    r_err  = bus.rsp_error;
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      check_val("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check_val("hold_rsp_rdata", bus.rsp_rdata, r_data);
      check_val("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_wdata = '0;   bus.rsp_ready = 1'b0; bus.a_ready = 1'b0;
    bus.d_opcode = '0; bus.d_param = '0; bus.d_size = '0; bus.d_source = '0;
    bus.d_sink = '0; bus.d_data = '0; bus.d_error = 1'b0; bus.d_valid = 1'b0;
    inj_op_en = 1'b0; inj_op = 3'd0; inj_src = 5'd0; inj_err = 1'b0; same_cycle = 1'b0;

    repeat (2) @(negedge CLK);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_a_valid", 64'(bus.a_valid), 64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_d_ready", 64'(bus.d_ready), 64'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check_val("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Full-width Get
    txn(1'b0, 32'h10, 4'd3, 64'h0, 0);
    check_val("get8_opcode", 64'(cap_op), 64'd4);
    check_val("get8_mask", 64'(cap_mask), 64'hFF);
    check_val("get8_rdata", r_data, 64'h17161514_13121110);
    check_val("get8_err", 64'(r_err), 64'd0);

    // Partial Put then read back
    txn(1'b1, 32'h12, 4'd1, 64'hBEEF, 0);
    check_val("put2_mask", 64'(cap_mask), 64'h0C);
    check_val("put2_opcode", 64'(cap_op), 64'd1);
    check_val("put2_data", 64'(cap_data[31:16]), 64'hBEEF);
    check_val("put2_err", 64'(r_err), 64'd0);
    check_val("put2_rdata", r_data, 64'h0);
    txn(1'b0, 32'h12, 4'd1, 64'h0, 0);
    check_val("get2_rdata", r_data, 64'hBEEF);

    // Full Put and sub-word Get from its upper half
    txn(1'b1, 32'h20, 4'd3, 64'h01234567_89ABCDEF, 0);
    check_val("putf_opcode", 64'(cap_op), 64'd0);
    check_val("putf_mask", 64'(cap_mask), 64'hFF);
    txn(1'b0, 32'h24, 4'd2, 64'h0, 0);
    check_val("get4_mask", 64'(cap_mask), 64'hF0);
    check_val("get4_rdata", r_data, 64'h01234567);
    txn(1'b0, 32'h17, 4'd0, 64'h0, 0);
    check_val("get1_rdata", r_data, 64'h17);

    // A and D in the same cycle, response held for 5 cycles
    same_cycle = 1'b1;
    txn(1'b0, 32'h10, 4'd2, 64'h0, 5);
    same_cycle = 1'b0;
    check_val("same_cyc_rdata", r_data, 64'hBEEF1110);
    check_val("same_cyc_err", 64'(r_err), 64'd0);

    // Illegal commands: oversize and misaligned
    send_req(1'b0, 32'h10, 4'd4, 64'h0);
    check_val("ill_size_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_val("ill_size_err", 64'(bus.rsp_error), 64'd1);
    check_val("ill_size_a_valid", 64'(bus.a_valid), 64'd0);
    bus.rsp_ready = 1'b1; @(negedge CLK); bus.rsp_ready = 1'b0;
    send_req(1'b1, 32'h3, 4'd1, 64'h1234);
    check_val("ill_align_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_val("ill_align_err", 64'(bus.rsp_error), 64'd1);
    check_val("ill_align_a_valid", 64'(bus.a_valid), 64'd0);
    bus.rsp_ready = 1'b1; @(negedge CLK); bus.rsp_ready = 1'b0;
    check_val("ill_after_a_valid", 64'(bus.a_valid), 64'd0);

    // Bad D beats
    inj_op_en = 1'b1; inj_op = 3'd0;
    txn(1'b0, 32'h10, 4'd3, 64'h0, 0);
    check_val("bad_opcode_err", 64'(r_err), 64'd1);
    inj_op_en = 1'b0; inj_src = 5'd7;
    txn(1'b0, 32'h10, 4'd3, 64'h0, 0);
    check_val("bad_source_err", 64'(r_err), 64'd1);
    inj_src = 5'd0; inj_err = 1'b1;
    txn(1'b0, 32'h10, 4'd3, 64'h0, 0);
    check_val("d_error_err", 64'(r_err), 64'd1);
    inj_err = 1'b0;
    txn(1'b0, 32'h08, 4'd3, 64'h0, 0);
    check_val("good_after_bad_err", 64'(r_err), 64'd0);
    check_val("good_after_bad_rdata", r_data, 64'h0F0E0D0C_0B0A0908);

    // Asynchronous reset while waiting for D
    send_req(1'b0, 32'h18, 4'd3, 64'h0);
    wait_a();
    bus.a_ready = 1'b1; @(negedge CLK); bus.a_ready = 1'b0;
    check_val("dwait_d_ready", 64'(bus.d_ready), 64'd1);
    #2 RESET = 1'b0;
    #1;
    check_val("arst_d_ready", 64'(bus.d_ready), 64'd0);
    check_val("arst_a_valid", 64'(bus.a_valid), 64'd0);
    check_val("arst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    txn(1'b0, 32'h18, 4'd2, 64'h0, 0);
    check_val("post_arst_rdata", r_data, 64'h1B1A1918);
    check_val("post_arst_err", 64'(r_err), 64'd0);

`ifdef TLUL_MASTER_TIMEOUT_EN
    // Silent slave: error response 5 cycles after A fire
    send_req(1'b0, 32'h10, 4'd3, 64'h0);
    wait_a();
    bus.a_ready = 1'b1; @(negedge CLK); bus.a_ready = 1'b0;
    repeat (4) @(negedge CLK);
    check_val("to_early_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge CLK);
    check_val("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_val("to_err", 64'(bus.rsp_error), 64'd1);
    held_data = bus.rsp_rdata;
    check_val("to_rdata", held_data, 64'h0);
    bus.rsp_ready = 1'b1; @(negedge CLK); bus.rsp_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
